// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet wave scheduler.
// Descriptor layout, FSM encoding and palette.
package bullet_pkg;

    localparam int DESC_W     = 36;
    localparam int POS_Y_LSB  = 0;
    localparam int POS_X_LSB  = 8;
    localparam int SIZE_X_LSB = 16;
    localparam int SIZE_Y_LSB = 24;
    localparam int COLOR_LSB  = 32;
    localparam int RENDER_BIT = 35;
    localparam int ROM_AW     = 5;

    localparam logic [2:0] WHITE = 3'd0;
    localparam logic [2:0] GREEN = 3'd1;
    localparam logic [2:0] BLUE  = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } sched_state_e;

    function automatic logic [DESC_W-1:0] mk_desc(
        input logic       render,
        input logic [2:0] color,
        input logic [7:0] size_y,
        input logic [7:0] size_x,
        input logic [7:0] pos_x,
        input logic [7:0] pos_y
    );
        logic [DESC_W-1:0] d;
        d = '0;
        d[RENDER_BIT]          = render;
        d[COLOR_LSB +: 3]      = color;
        d[SIZE_Y_LSB +: 8]     = size_y;
        d[SIZE_X_LSB +: 8]     = size_x;
        d[POS_X_LSB +: 8]      = pos_x;
        d[POS_Y_LSB +: 8]      = pos_y;
        return d;
    endfunction

endpackage

// File: rtl/bullet_wave_scheduler_if.sv
// Scheduler <-> bullet table port bundle.
// The scheduler writes descriptors and pulses; the table reports hits.
interface bullet_wave_scheduler_if
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 3
);
    logic                   wr_en;
    logic [2:0]             wr_idx;
    logic [DESC_W-1:0]      wr_data;
    logic                   step;
    logic [NUM_BULLETS-1:0] clr_mask;
    logic [NUM_BULLETS-1:0] hit_mask;

    modport master (
        output wr_en, wr_idx, wr_data, step, clr_mask,
        input  hit_mask
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, step, clr_mask,
        output hit_mask
    );
endinterface

// File: rtl/bullet_pattern_rom.sv
// Attack pattern ROM, addressed by wave*NUM_BULLETS+slot.
// Unlisted addresses return a non-rendering blank descriptor.
module bullet_pattern_rom
    import bullet_pkg::*;
(
    input  logic [ROM_AW-1:0] addr,
    output logic [DESC_W-1:0] desc
);
    always_comb begin
        desc = '0;
        case (addr)
            5'd0:  desc = mk_desc(1'b1, WHITE, 8'd8,  8'd8,  8'h10, 8'h20);
            5'd1:  desc = mk_desc(1'b1, GREEN, 8'd8,  8'd8,  8'h40, 8'h20);
            5'd2:  desc = mk_desc(1'b1, BLUE,  8'd8,  8'd8,  8'h70, 8'h20);
            5'd3:  desc = mk_desc(1'b1, WHITE, 8'd4,  8'd4,  8'h20, 8'h10);
            5'd4:  desc = mk_desc(1'b1, GREEN, 8'd4,  8'd4,  8'h60, 8'h10);
            5'd5:  desc = mk_desc(1'b0, BLUE,  8'd4,  8'd4,  8'hA0, 8'h10);
            5'd6:  desc = mk_desc(1'b1, BLUE,  8'd16, 8'd16, 8'h30, 8'h30);
            5'd7:  desc = mk_desc(1'b1, BLUE,  8'd16, 8'd16, 8'h80, 8'h30);
            5'd8:  desc = mk_desc(1'b1, GREEN, 8'd6,  8'd6,  8'hC0, 8'h40);
            5'd9:  desc = mk_desc(1'b1, WHITE, 8'd12, 8'd12, 8'h20, 8'h50);
            5'd10: desc = mk_desc(1'b1, GREEN, 8'd12, 8'd12, 8'h60, 8'h50);
            5'd11: desc = mk_desc(1'b1, BLUE,  8'd12, 8'd12, 8'hA0, 8'h50);
            default: desc = '0;
        endcase
    end
endmodule

// File: rtl/bullet_wave_scheduler.sv
// Wave sequencer for the bullet table: load, run, flush, gap, repeat.
// All outputs are registered from the next-state decode.
module bullet_wave_scheduler
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS = 3,
    parameter int NUM_WAVES   = 4,
    parameter int WAVE_FRAMES = 120,
    parameter int GAP_FRAMES  = 30
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    frame_tick,
    bullet_wave_scheduler_if.master tbl,
    output logic [1:0]              wave_idx,
    output logic                    busy,
    output logic                    done
);
    localparam logic [NUM_BULLETS-1:0] ALL = '1;

    sched_state_e           state, nstate;
    logic [2:0]             slot, slot_n;
    logic [7:0]             frame_cnt, frame_n;
    logic [7:0]             gap_cnt, gap_n;
    logic [NUM_BULLETS-1:0] alive, alive_base, alive_n, hv;
    logic [NUM_BULLETS-1:0] clr_n;
    logic [1:0]             wave_n;
    logic                   load_n, step_n;
    logic [ROM_AW-1:0]      rom_addr;
    logic [DESC_W-1:0]      rom_desc;

    always_comb begin
        nstate     = state;
        wave_n     = wave_idx;
        slot_n     = slot;
        frame_n    = frame_cnt;
        gap_n      = gap_cnt;
        alive_base = alive;
        hv         = tbl.hit_mask & alive;
        clr_n      = '0;
        step_n     = 1'b0;
        load_n     = 1'b0;
        if (abort) begin
            nstate     = S_IDLE;
            wave_n     = '0;
            slot_n     = '0;
            frame_n    = '0;
            gap_n      = '0;
            alive_base = '0;
            if (state == S_LOAD || state == S_RUN) clr_n = ALL;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nstate     = S_LOAD;
                        wave_n     = '0;
                        slot_n     = '0;
                        frame_n    = '0;
                        alive_base = '0;
                        load_n     = 1'b1;
                    end
                end
                S_LOAD: begin
                    frame_n = '0;
                    if (slot == 3'(NUM_BULLETS - 1)) begin
                        nstate = S_RUN;
                        slot_n = '0;
                    end else begin
                        slot_n = slot + 3'd1;
                        load_n = 1'b1;
                    end
                end
                S_RUN: begin
                    alive_base = alive & ~hv;
                    clr_n      = hv;
                    if (frame_tick) begin
                        step_n  = 1'b1;
                        frame_n = frame_cnt + 8'd1;
                    end
                    // Ending the wave flushes everything still alive, hit or not
                    if ((frame_tick && frame_n == 8'(WAVE_FRAMES)) ||
                        alive_base == '0) begin
                        nstate     = S_GAP;
                        clr_n      = alive;
                        alive_base = '0;
                        gap_n      = '0;
                    end
                end
                S_GAP: begin
                    if (GAP_FRAMES == 0 ||
                        (frame_tick && gap_cnt + 8'd1 == 8'(GAP_FRAMES))) begin
                        gap_n = '0;
                        if (wave_idx == 2'(NUM_WAVES - 1)) begin
                            nstate = S_DONE;
                        end else begin
                            nstate  = S_LOAD;
                            wave_n  = wave_idx + 2'd1;
                            slot_n  = '0;
                            frame_n = '0;
                            load_n  = 1'b1;
                        end
                    end else if (frame_tick) begin
                        gap_n = gap_cnt + 8'd1;
                    end
                end
                default: nstate = S_IDLE;
            endcase
        end
    end

    assign rom_addr = ROM_AW'(wave_n) * ROM_AW'(NUM_BULLETS) + ROM_AW'(slot_n);

    bullet_pattern_rom u_rom (
        .addr (rom_addr),
        .desc (rom_desc)
    );

    always_comb begin
        alive_n = alive_base;
        if (load_n)
            alive_n = alive_base |
                (NUM_BULLETS'(rom_desc[RENDER_BIT]) << slot_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wave_idx     <= '0;
            slot         <= '0;
            frame_cnt    <= '0;
            gap_cnt      <= '0;
            alive        <= '0;
            tbl.wr_en    <= 1'b0;
            tbl.wr_idx   <= '0;
            tbl.wr_data  <= '0;
            tbl.step     <= 1'b0;
            tbl.clr_mask <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= nstate;
            wave_idx     <= wave_n;
            slot         <= slot_n;
            frame_cnt    <= frame_n;
            gap_cnt      <= gap_n;
            alive        <= alive_n;
            tbl.wr_en    <= load_n;
            tbl.wr_idx   <= load_n ? slot_n : 3'd0;
            tbl.wr_data  <= load_n ? rom_desc : '0;
            tbl.step     <= step_n;
            tbl.clr_mask <= clr_n;
            busy         <= nstate inside {S_LOAD, S_RUN, S_GAP};
            done         <= nstate == S_DONE;
        end
    end
endmodule

// File: tb/tb_bullet_wave_scheduler.sv
// Directed bench for bullet_wave_scheduler: a long-budget instance (A)
// and a short two-wave instance (B) sharing tick and abort.
module tb_bullet_wave_scheduler;
    import bullet_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       abort = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] wave_a, wave_b;
    logic       busy_a, busy_b, done_a, done_b;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [35:0] rom_exp [6] = '{
        36'h8_0808_1020, 36'h9_0808_4020, 36'hA_0808_7020,
        36'h8_0404_2010, 36'h9_0404_6010, 36'h2_0404_A010
    };

    bullet_wave_scheduler_if #(.NUM_BULLETS(3)) a_if ();
    bullet_wave_scheduler_if #(.NUM_BULLETS(3)) b_if ();

    always #5 clk = ~clk;

    bullet_wave_scheduler #(
        .NUM_BULLETS(3), .NUM_WAVES(4), .WAVE_FRAMES(120), .GAP_FRAMES(30)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .frame_tick(frame_tick), .tbl(a_if),
        .wave_idx(wave_a), .busy(busy_a), .done(done_a)
    );

    bullet_wave_scheduler #(
        .NUM_BULLETS(3), .NUM_WAVES(2), .WAVE_FRAMES(4), .GAP_FRAMES(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .frame_tick(frame_tick), .tbl(b_if),
        .wave_idx(wave_b), .busy(busy_b), .done(done_b)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_if.hit_mask = '0;
        b_if.hit_mask = '0;
        rst_n = 1'b0;
        repeat (2) cyc();
        n_cmp++;
        if ({a_if.wr_en, a_if.step, a_if.clr_mask, busy_a, done_a, wave_a} !== 9'd0) begin
            n_bad++; $display("FAIL reset_a got=%b exp=0",
                {a_if.wr_en, a_if.step, a_if.clr_mask, busy_a, done_a, wave_a});
        end
        n_cmp++;
        if ({b_if.wr_en, b_if.wr_data, busy_b, done_b, wave_b} !== 41'd0) begin
            n_bad++; $display("FAIL reset_b got=%h exp=0",
                {b_if.wr_en, b_if.wr_data, busy_b, done_b, wave_b});
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_load();
        start_a = 1'b1; cyc(); start_a = 1'b0;
        n_cmp++;
        if ({busy_a, wave_a} !== 3'b100) begin
            n_bad++; $display("FAIL load_busy got=%b exp=100", {busy_a, wave_a});
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({a_if.wr_en, a_if.wr_idx} !== {1'b1, 3'(k)}) begin
                n_bad++; $display("FAIL load_idx%0d got=%b exp=1_%0d",
                    k, {a_if.wr_en, a_if.wr_idx}, k);
            end
            n_cmp++;
            if (a_if.wr_data !== rom_exp[k]) begin
                n_bad++; $display("FAIL load_data%0d got=%h exp=%h",
                    k, a_if.wr_data, rom_exp[k]);
            end
            cyc();
        end
        n_cmp++;
        if (a_if.wr_en !== 1'b0) begin
            n_bad++; $display("FAIL load_end got=%b exp=0", a_if.wr_en);
        end
    endtask

    task automatic test_step();
        logic [9:0] pat = 10'b0001110101;
        int nstep = 0;
        for (int i = 0; i < 10; i++) begin
            frame_tick = pat[i];
            cyc();
            nstep += int'(a_if.step);
            n_cmp++;
            if (a_if.step !== pat[i]) begin
                n_bad++; $display("FAIL step_c%0d got=%b exp=%b", i, a_if.step, pat[i]);
            end
        end
        frame_tick = 1'b0;
        cyc();
        n_cmp++;
        if (nstep !== 5 || a_if.step !== 1'b0) begin
            n_bad++; $display("FAIL step_count got=%0d/%b exp=5/0", nstep, a_if.step);
        end
    endtask

    task automatic test_hit();
        a_if.hit_mask = 3'b010; cyc(); a_if.hit_mask = '0;
        n_cmp++;
        if (a_if.clr_mask !== 3'b010) begin
            n_bad++; $display("FAIL hit_clr got=%b exp=010", a_if.clr_mask);
        end
        cyc();
        n_cmp++;
        if (a_if.clr_mask !== 3'b000) begin
            n_bad++; $display("FAIL hit_pulse got=%b exp=000", a_if.clr_mask);
        end
        a_if.hit_mask = 3'b010; cyc(); a_if.hit_mask = '0;
        n_cmp++;
        if (a_if.clr_mask !== 3'b000) begin
            n_bad++; $display("FAIL hit_dead got=%b exp=000", a_if.clr_mask);
        end
        start_a = 1'b1; cyc(); start_a = 1'b0;
        n_cmp++;
        if ({a_if.wr_en, busy_a} !== 2'b01) begin
            n_bad++; $display("FAIL start_busy got=%b exp=01", {a_if.wr_en, busy_a});
        end
    endtask

    task automatic test_abort();
        a_if.hit_mask = 3'b001; abort = 1'b1;
        cyc();
        a_if.hit_mask = '0; abort = 1'b0;
        n_cmp++;
        if ({a_if.clr_mask, busy_a} !== 4'b1110) begin
            n_bad++; $display("FAIL abort_clr got=%b exp=1110", {a_if.clr_mask, busy_a});
        end
        cyc();
        n_cmp++;
        if ({a_if.clr_mask, a_if.wr_en, busy_a, done_a, wave_a} !== 8'd0) begin
            n_bad++; $display("FAIL abort_idle got=%b exp=0",
                {a_if.clr_mask, a_if.wr_en, busy_a, done_a, wave_a});
        end
        start_a = 1'b1; cyc(); start_a = 1'b0;
        n_cmp++;
        if ({a_if.wr_en, a_if.wr_idx, wave_a, a_if.wr_data} !== {6'b1_000_00, rom_exp[0]}) begin
            n_bad++; $display("FAIL abort_reload got=%b_%h exp=100000_%h",
                {a_if.wr_en, a_if.wr_idx, wave_a}, a_if.wr_data, rom_exp[0]);
        end
        repeat (3) cyc();
    endtask

    task automatic test_all_hit();
        repeat (2) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
        end
        a_if.hit_mask = 3'b111; cyc(); a_if.hit_mask = '0;
        n_cmp++;
        if ({a_if.clr_mask, busy_a} !== 4'b1111) begin
            n_bad++; $display("FAIL allhit_clr got=%b exp=1111", {a_if.clr_mask, busy_a});
        end
        cyc();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        n_cmp++;
        if ({a_if.step, a_if.wr_en, a_if.clr_mask, busy_a} !== 6'b000001) begin
            n_bad++; $display("FAIL allhit_gap got=%b exp=000001",
                {a_if.step, a_if.wr_en, a_if.clr_mask, busy_a});
        end
        abort = 1'b1; cyc(); abort = 1'b0;
        n_cmp++;
        if ({a_if.clr_mask, busy_a} !== 4'b0000) begin
            n_bad++; $display("FAIL gap_abort got=%b exp=0000", {a_if.clr_mask, busy_a});
        end
    endtask

    task automatic test_waves();
        start_b = 1'b1; cyc(); start_b = 1'b0;
        n_cmp++;
        if ({b_if.wr_en, b_if.wr_idx, b_if.wr_data} !== {4'b1000, rom_exp[0]}) begin
            n_bad++; $display("FAIL w0_load got=%b_%h", {b_if.wr_en, b_if.wr_idx}, b_if.wr_data);
        end
        repeat (3) cyc();
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            n_cmp++;
            if ({b_if.step, b_if.clr_mask} !== 4'b1000) begin
                n_bad++; $display("FAIL w0_tick%0d got=%b exp=1000", i, {b_if.step, b_if.clr_mask});
            end
            cyc();
        end
        frame_tick = 1'b1; b_if.hit_mask = 3'b001;
        cyc();
        frame_tick = 1'b0; b_if.hit_mask = '0;
        n_cmp++;
        if ({b_if.step, b_if.clr_mask, busy_b} !== 5'b11111) begin
            n_bad++; $display("FAIL w0_flush got=%b exp=11111", {b_if.step, b_if.clr_mask, busy_b});
        end
        cyc();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        n_cmp++;
        if ({b_if.wr_en, b_if.step, b_if.clr_mask} !== 5'd0) begin
            n_bad++; $display("FAIL gap_tick got=%b exp=00000",
                {b_if.wr_en, b_if.step, b_if.clr_mask});
        end
        cyc();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({b_if.wr_en, b_if.wr_idx, wave_b, b_if.wr_data} !==
                {1'b1, 3'(k), 2'd1, rom_exp[3 + k]}) begin
                n_bad++; $display("FAIL w1_load%0d got=%b_%h exp=%h", k,
                    {b_if.wr_en, b_if.wr_idx, wave_b}, b_if.wr_data, rom_exp[3 + k]);
            end
            cyc();
        end
        b_if.hit_mask = 3'b111; cyc(); b_if.hit_mask = '0;
        n_cmp++;
        if ({b_if.clr_mask, busy_b} !== 4'b0111) begin
            n_bad++; $display("FAIL w1_clr got=%b exp=0111", {b_if.clr_mask, busy_b});
        end
        cyc();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        n_cmp++;
        if ({done_b, busy_b, wave_b} !== 4'b1001) begin
            n_bad++; $display("FAIL done got=%b exp=1001", {done_b, busy_b, wave_b});
        end
        cyc();
        n_cmp++;
        if ({done_b, busy_b, wave_b, b_if.wr_en} !== 5'b10010) begin
            n_bad++; $display("FAIL done_hold got=%b exp=10010",
                {done_b, busy_b, wave_b, b_if.wr_en});
        end
        start_b = 1'b1; cyc(); start_b = 1'b0;
        n_cmp++;
        if ({done_b, busy_b, wave_b, b_if.wr_en} !== 5'b01001) begin
            n_bad++; $display("FAIL restart got=%b exp=01001",
                {done_b, busy_b, wave_b, b_if.wr_en});
        end
        abort = 1'b1; cyc(); abort = 1'b0; cyc();
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_hit();
        test_abort();
        test_all_hit();
        test_waves();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
